seq_mag_cmp: RTL

Parametrised, digit-serial magnitude comparator. It compares two WIDTH-bit operands MSB-digit-first, one DIGIT-bit slice per clock, and stops at the first differing digit. It is the multi-cycle, handshaked successor to the combinational 32-bit nibble-cascade comparator, and adds a signed mode, early termination and registered, held results. It sits between operand registers and sorting/selection logic where a single-cycle wide compare does not meet timing.

---
 rtl/seq_mag_cmp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_mag_cmp.sv
// Digit-serial magnitude comparator: walks WIDTH-bit operands MSB digit first,
// DIGIT bits per clock, and stops at the first differing digit.
module seq_mag_cmp #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lt,
  input  logic [WIDTH-1:0] rt,
  input  logic             signed_mode,
  input  logic             sm_in,
  input  logic             lg_in,
  output logic             busy,
  output logic             done,
  output logic             lt_o,
  output logic             gt_o,
  output logic             eq_o,
  output logic [1:0]       o_dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a compare is accepted on any rising edge where start=1 and the
  // FSM is not in RUN; busy is high in RUN and done pulses for the single
  // DONE cycle in which lt_o/gt_o/eq_o first hold the new result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_lt;
  logic [WIDTH-1:0] r_rt;
  logic             r_signed;
  logic             r_sm;
  logic             r_lg;
  logic [KW-1:0]    r_k;
  logic             r_lt_o;
  logic             r_gt_o;
  logic             r_eq_o;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic [DIGIT-1:0] w_mask;
  logic [DIGIT-1:0] w_dig_l;
  logic [DIGIT-1:0] w_dig_r;
  logic             w_set_lt;
  logic             w_set_gt;
  logic             w_set_eq;
  logic             w_decide;

  assign w_accept = start && (r_state != S_RUN);
  assign w_first  = (r_k == '0);
  assign w_last   = (r_k == KW'(N - 1));

  // Flipping the top bit of the most-significant digit maps two's-complement
  // ordering onto unsigned ordering; lower digits are plain magnitude.
  always_comb begin
    w_mask            = '0;
    w_mask[DIGIT-1]   = r_signed && w_first;
  end

  assign w_dig_l = r_lt[WIDTH-1 -: DIGIT] ^ w_mask;
  assign w_dig_r = r_rt[WIDTH-1 -: DIGIT] ^ w_mask;

  // Cascade inputs pre-empt the digit walk; sm_in outranks lg_in.
  always_comb begin
    w_set_lt = 1'b0;
    w_set_gt = 1'b0;
    w_set_eq = 1'b0;
    if (r_state == S_RUN) begin
      if (w_first && r_sm)          w_set_lt = 1'b1;
      else if (w_first && r_lg)     w_set_gt = 1'b1;
      else if (w_dig_l < w_dig_r)   w_set_lt = 1'b1;
      else if (w_dig_l > w_dig_r)   w_set_gt = 1'b1;
      else if (w_last)              w_set_eq = 1'b1;
    end
  end

  assign w_decide = w_set_lt || w_set_gt || w_set_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_decide) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == S_RUN);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lt     <= '0;
      r_rt     <= '0;
      r_signed <= 1'b0;
      r_sm     <= 1'b0;
      r_lg     <= 1'b0;
      r_k      <= '0;
      r_lt_o   <= 1'b0;
      r_gt_o   <= 1'b0;
      r_eq_o   <= 1'b0;
    end else if (w_accept) begin
      r_lt     <= lt;
      r_rt     <= rt;
      r_signed <= signed_mode;
      r_sm     <= sm_in;
      r_lg     <= lg_in;
      r_k      <= '0;
      r_lt_o   <= 1'b0;
      r_gt_o   <= 1'b0;
      r_eq_o   <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_decide) begin
        r_lt_o <= w_set_lt;
        r_gt_o <= w_set_gt;
        r_eq_o <= w_set_eq;
      end else begin
        r_lt <= r_lt << DIGIT;
        r_rt <= r_rt << DIGIT;
        r_k  <= r_k + KW'(1);
      end
    end
  end

  assign lt_o = r_lt_o;
  assign gt_o = r_gt_o;
  assign eq_o = r_eq_o;

endmodule
